// File: rtl/bcd_seq_ctrl.sv
// Sequential double-dabble binary-to-BCD converter with valid/ready on both sides.
// One input bit is processed per clock through a single shared set of add-3 correctors.
module bcd_seq_ctrl #(
  parameter int BIN_WIDTH = 28,
  parameter int DIGITS    = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BIN_WIDTH-1:0]  in_bin,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   out_bcd,
  output logic                  out_ovf,
  output logic [DIGITS-1:0]     out_digit_en
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(BIN_WIDTH + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

  state_e               state_q, state_d;
  logic [BIN_WIDTH-1:0] bin_q, bin_d;
  logic [BW-1:0]        acc_q, acc_d;
  logic                 ovf_q, ovf_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [BW-1:0]        out_bcd_q;
  logic                 out_ovf_q;
  logic [DIGITS-1:0]    out_en_q;

  logic [BW-1:0]        corr;
  logic [DIGITS-1:0]    en_calc;
  logic                 any_nz;
  logic                 load_out;

  always_comb begin
    corr = acc_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (acc_q[4*i +: 4] > 4'd4) begin
        corr[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
      end
    end
  end

  // Digit i is lit when it or any more significant digit is nonzero.
  always_comb begin
    en_calc = '0;
    any_nz  = 1'b0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      any_nz     = any_nz | (|acc_q[4*i +: 4]);
      en_calc[i] = any_nz;
    end
    en_calc[0] = 1'b1;
  end

  always_comb begin
    state_d  = state_q;
    bin_d    = bin_q;
    acc_d    = acc_q;
    ovf_d    = ovf_q;
    cnt_d    = cnt_q;
    load_out = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          bin_d   = in_bin;
          acc_d   = '0;
          ovf_d   = 1'b0;
          cnt_d   = CW'(BIN_WIDTH);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        // The cycle after the last shift is spent registering the result.
        if (cnt_q == '0) begin
          load_out = 1'b1;
          state_d  = DONE;
        end else begin
          acc_d = {corr[BW-2:0], bin_q[BIN_WIDTH-1]};
          bin_d = {bin_q[BIN_WIDTH-2:0], 1'b0};
          cnt_d = cnt_q - CW'(1);
          if (corr[BW-1]) begin
            ovf_d = 1'b1;
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (clr) begin
      state_d  = IDLE;
      load_out = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      bin_q   <= '0;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_bcd_q <= '0;
      out_ovf_q <= 1'b0;
      out_en_q  <= DIGITS'(1);
    end else if (load_out) begin
      out_bcd_q <= acc_q;
      out_ovf_q <= ovf_q;
      out_en_q  <= en_calc;
    end
  end

  assign in_ready     = (state_q == IDLE);
  assign out_valid    = (state_q == DONE);
  assign out_bcd      = out_bcd_q;
  assign out_ovf      = out_ovf_q;
  assign out_digit_en = out_en_q;

endmodule

// File: tb/tb_bcd_seq_ctrl.sv
// Self-checking bench for bcd_seq_ctrl: directed boundary values, random values,
// backpressure, synchronous abort and asynchronous reset against an arithmetic model.
module tb_bcd_seq_ctrl;

  localparam int W       = 28;
  localparam int D       = 8;
  localparam int EXP_LAT = W + 1;
  localparam int MAX_LAT = 200;

  logic           clk;
  logic           rst_n;
  logic           clr;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   in_bin;
  logic           out_valid;
  logic           out_ready;
  logic [4*D-1:0] out_bcd;
  logic           out_ovf;
  logic [D-1:0]   out_digit_en;

  int total;
  int bad;
  longint last_val;

  bcd_seq_ctrl #(.BIN_WIDTH(W), .DIGITS(D)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .clr          (clr),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_bin       (in_bin),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_bcd      (out_bcd),
    .out_ovf      (out_ovf),
    .out_digit_en (out_digit_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [4*D-1:0] model_bcd(input longint v);
    logic [4*D-1:0] r;
    longint x;
    r = '0;
    x = v;
    for (int i = 0; i < D; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic model_ovf(input longint v);
    return v >= 64'd100000000;
  endfunction

  function automatic logic [D-1:0] model_en(input longint v);
    logic [D-1:0] e;
    longint x;
    int top;
    x = v % 64'd100000000;
    top = 0;
    for (int i = 0; i < D; i++) begin
      if (x > 0) top = i;
      x = x / 10;
    end
    e = '0;
    for (int i = 0; i <= top; i++) e[i] = 1'b1;
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offers v, waits for out_valid (bounded), captures outputs, then takes the result.
  task automatic convert(input longint v, input bit take, output int lat,
                         output logic [4*D-1:0] bcd, output logic ovf, output logic [D-1:0] en);
    in_valid = 1'b1;
    in_bin   = W'(v);
    tick();
    in_valid = 1'b0;
    in_bin   = W'($urandom);
    lat = 0;
    while (!out_valid && lat < MAX_LAT) begin
      tick();
      lat++;
    end
    bcd = out_bcd;
    ovf = out_ovf;
    en  = out_digit_en;
    if (take) begin
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
    end
  endtask

  task automatic check_conversion(input string tag, input longint v);
    int lat;
    logic [4*D-1:0] bcd;
    logic ovf;
    logic [D-1:0] en;
    convert(v, 1'b1, lat, bcd, ovf, en);
    total++;
    if (lat !== EXP_LAT) begin
      bad++;
      $display("[TB] FAIL %s latency v=%0d got=%0d want=%0d", tag, v, lat, EXP_LAT);
    end
    total++;
    if (bcd !== model_bcd(v)) begin
      bad++;
      $display("[TB] FAIL %s bcd v=%0d got=%h want=%h", tag, v, bcd, model_bcd(v));
    end
    total++;
    if (ovf !== model_ovf(v)) begin
      bad++;
      $display("[TB] FAIL %s ovf v=%0d got=%b want=%b", tag, v, ovf, model_ovf(v));
    end
    total++;
    if (en !== model_en(v)) begin
      bad++;
      $display("[TB] FAIL %s digit_en v=%0d got=%h want=%h", tag, v, en, model_en(v));
    end
    last_val = v;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; in_bin = '0; out_ready = 1'b0;
    repeat (3) tick();
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset in_ready got=%b want=1", in_ready); end
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset out_valid got=%b want=0", out_valid); end
    total++;
    if (out_bcd !== '0) begin bad++; $display("[TB] FAIL reset out_bcd got=%h want=0", out_bcd); end
    total++;
    if (out_ovf !== 1'b0) begin bad++; $display("[TB] FAIL reset out_ovf got=%b want=0", out_ovf); end
    total++;
    if (out_digit_en !== D'(1)) begin bad++; $display("[TB] FAIL reset digit_en got=%h want=01", out_digit_en); end
    #2 rst_n = 1'b1;
    tick();
  endtask

  task automatic test_directed();
    longint vals[6] = '{64'd12345678, 64'd0, 64'd405, 64'd99999999, 64'd100000000, 64'd268435455};
    foreach (vals[i]) check_conversion("directed", vals[i]);
  endtask

  task automatic test_random();
    for (int i = 0; i < 20; i++) begin
      if (i % 2 == 0) check_conversion("random_full", longint'($urandom & 32'h0FFF_FFFF));
      else            check_conversion("random_inrange", longint'($urandom_range(0, 99999999)));
    end
  endtask

  task automatic test_back_to_back();
    longint v1, v2;
    int lat;
    logic [4*D-1:0] bcd;
    logic ovf;
    logic [D-1:0] en;
    v1 = longint'($urandom_range(0, 99999999));
    v2 = longint'($urandom & 32'h0FFF_FFFF);
    convert(v1, 1'b0, lat, bcd, ovf, en);
    in_valid = 1'b1;
    in_bin   = W'(v2);
    for (int c = 0; c < 10; c++) begin
      total++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_bcd !== model_bcd(v1) || out_digit_en !== model_en(v1)) begin
        bad++;
        $display("[TB] FAIL backpressure_hold cyc=%0d valid=%b ready=%b bcd=%h want valid=1 ready=0 bcd=%h",
                 c, out_valid, in_ready, out_bcd, model_bcd(v1));
      end
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("[TB] FAIL backpressure_release valid=%b ready=%b want valid=0 ready=1", out_valid, in_ready);
    end
    check_conversion("backpressure_next", v2);
  endtask

  task automatic test_clr();
    longint prev, v;
    int seen;
    prev = last_val;
    v = longint'($urandom_range(1, 99999999));
    in_valid = 1'b1;
    in_bin   = W'(v);
    tick();
    in_valid = 1'b0;
    repeat (9) tick();
    clr      = 1'b1;
    in_valid = 1'b1;
    in_bin   = W'($urandom);
    tick();
    clr      = 1'b0;
    in_valid = 1'b0;
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++;
      $display("[TB] FAIL clr_idle ready=%b valid=%b want ready=1 valid=0", in_ready, out_valid);
    end
    total++;
    if (out_bcd !== model_bcd(prev) || out_digit_en !== model_en(prev)) begin
      bad++;
      $display("[TB] FAIL clr_keep bcd=%h en=%h want bcd=%h en=%h", out_bcd, out_digit_en, model_bcd(prev), model_en(prev));
    end
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      if (out_valid) seen++;
      tick();
    end
    total++;
    if (seen !== 0) begin
      bad++;
      $display("[TB] FAIL clr_no_valid got=%0d valid cycles want=0", seen);
    end
    check_conversion("after_clr", longint'($urandom & 32'h0FFF_FFFF));
  endtask

  task automatic test_async_reset();
    in_valid = 1'b1;
    in_bin   = W'(64'd99999999);
    tick();
    in_valid = 1'b0;
    repeat (5) tick();
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_bcd !== '0 || out_ovf !== 1'b0 || out_digit_en !== D'(1)) begin
      bad++;
      $display("[TB] FAIL async_reset ready=%b valid=%b bcd=%h ovf=%b en=%h want 1 0 0 0 01",
               in_ready, out_valid, out_bcd, out_ovf, out_digit_en);
    end
    repeat (2) tick();
    #2 rst_n = 1'b1;
    tick();
    check_conversion("after_reset", 64'd7);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    last_val = 0;
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_clr();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bcd_seq_ctrl.md
Name: bcd_seq_ctrl

Overview:
Sequential binary-to-BCD conversion controller for the display path. It accepts a binary value over a valid/ready handshake and runs the double-dabble algorithm one bit per clock, using a single shared set of per-digit add-3 correctors. It returns packed BCD digits, an overflow flag and a leading-zero blanking mask over a second valid/ready handshake. It sits between the accelerometer/score datapath and the 7-segment scan driver, and replaces the purely combinational converter, trading latency for area.

Parameters:
BIN_WIDTH, 28, width of binary input; legal range 4..32.
DIGITS, 8, number of BCD output digits; BCD bus width is 4*DIGITS.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
clr  input  1  synchronous abort: return to IDLE, drop any conversion or result.
in_valid  input  1  input value offered.
in_ready  output  1  block can accept an input.
in_bin  input  BIN_WIDTH  unsigned binary value.
out_valid  output  1  result available.
out_ready  input  1  consumer takes the result.
out_bcd  output  4*DIGITS  packed BCD; digit 0 (units) is bits [3:0].
out_ovf  output  1  value was >= 10^DIGITS; out_bcd holds the value mod 10^DIGITS.
out_digit_en  output  DIGITS  blanking mask: bit i set if digit i or any higher digit is nonzero; bit 0 always set.

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE; in_ready=1, out_valid=0, out_bcd=0, out_ovf=0, out_digit_en=1 (only bit 0 set). Internal shift register and bit counter are cleared.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: latch in_bin into the shift register, clear the BCD accumulator and ovf, set bit counter to BIN_WIDTH, go to SHIFT.
- SHIFT (in_ready=0, out_valid=0). Each cycle:
  - (a) Every accumulator digit >4 gets +3 (4-bit, no carry between digits).
  - (b) If the corrected top digit has bit 3 set, set ovf (sticky).
  - (c) Shift {accumulator, binary} left by 1; the binary MSB enters accumulator bit 0.
  - (d) Decrement the counter; when it reaches 0, go to DONE.
  - Exactly BIN_WIDTH cycles are spent in SHIFT.
- Latency: handshake at edge k gives out_valid=1 after edge k+BIN_WIDTH+1. The extra cycle registers out_bcd, out_ovf and out_digit_en.
- DONE:
  - out_valid=1; outputs are stable while out_valid&!out_ready.
  - On out_ready, return to IDLE: out_valid drops the next cycle and in_ready rises the same edge.
  - No input is accepted in DONE (in_ready=0), so there is no back-to-back overlap.
- out_bcd, out_ovf and out_digit_en are updated only on entering DONE. They hold their last value in IDLE/SHIFT and are not cleared by a handshake.
- out_digit_en is computed from the final BCD as a prefix-OR from the top digit down, with bit 0 forced to 1.
- clr has priority over every handshake in any state:
  - next state IDLE, out_valid=0, in_ready=1;
  - out_bcd, out_ovf and out_digit_en keep their values;
  - a simultaneous in_valid on the clr cycle is ignored.
- in_bin is sampled only on the accept edge; later changes have no effect.
- Reset mid-SHIFT or mid-DONE: immediate return to reset values; the partial result is discarded.

Test Plan:
- Reset, then in_bin=12345678 (BIN_WIDTH=28) with out_ready=1 -> out_valid rises 29 cycles after accept; out_bcd=0x12345678, out_ovf=0, out_digit_en=0xFF.
- in_bin=0 -> out_bcd=0x00000000, out_ovf=0, out_digit_en=0x01; in_bin=405 -> out_bcd=0x00000405, out_digit_en=0x07.
- Boundary values:
  - in_bin=99999999 -> out_bcd=0x99999999, out_ovf=0.
  - in_bin=100000000 -> out_bcd=0x00000000, out_ovf=1.
  - in_bin=268435455 -> out_bcd=0x68435455, out_ovf=1.
- Backpressure: hold out_ready=0 for 10 cycles in DONE with in_valid=1 and a new in_bin -> outputs stable, in_ready=0, nothing accepted. Raise out_ready -> IDLE next cycle, new value accepted, correct result for the new value.
- Assert clr at SHIFT cycle 10 -> IDLE next cycle, out_valid never rises, in_ready=1. The previous result stays on out_bcd, and the next conversion is correct.
- Deassert rst_n asynchronously mid-SHIFT -> outputs at reset values immediately without waiting for a clock edge. After release, conversion of 7 -> out_bcd=0x7, out_digit_en=0x01.
